muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with its own controller, sitting beside the single-cycle execute ALU in the Minisys CPU. It owns the HI/LO registers and sequences one shift-add or shift-subtract step per clock for mult/multu/div/divu. It raises a stall request so the CPU control unit freezes the pipeline until the result is ready. It also services mthi/mtlo writes and drives HI/LO for mfhi/mflo.

Parameters:
DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  launch operation; sampled only in IDLE
op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu
Read_data_1  input  DATA_W  rs operand (multiplicand / dividend)
Read_data_2  input  DATA_W  rt operand (multiplier / divisor)
wr_hi  input  1  mthi write strobe
wr_lo  input  1  mtlo write strobe
wr_data  input  DATA_W  data for mthi/mtlo
busy  output  1  operation in progress
stall_req  output  1  pipeline stall request to the control unit
done  output  1  one-cycle completion pulse
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register

Behaviour:
- Reset values: busy=0, stall_req=0, done=0, hi=0, lo=0, state=IDLE, iteration counter=0.
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - latch operand magnitudes (abs value for signed ops; raw value for unsigned ops) and the result sign flags;
  - clear the accumulator and counter;
  - go to RUN.
- RUN, mult/multu: one shift-add step per cycle into a 2*DATA_W product.
- RUN, div/divu: one restoring shift-subtract step per cycle, producing quotient and remainder.
- RUN exit: after exactly DATA_W iterations (counter = DATA_W-1 on the last step), go to FIX.
- FIX: apply sign correction, write hi/lo, return to IDLE, and set done=1 for the following cycle only.
  - Signed product: negate when operand signs differ.
  - Signed quotient: negate when operand signs differ.
  - Signed remainder: takes the sign of the dividend.
- Latency: start sampled at edge t0; hi/lo updated at edge t0+DATA_W+1; done high during the cycle after that edge. With DATA_W=32, done is high in the 34th cycle after the start cycle.
- Result mapping:
  - mult: hi = product[2W-1:W], lo = product[W-1:0].
  - div: lo = quotient, hi = remainder.
- busy = 1 in RUN and FIX. stall_req = busy | (start & IDLE), so the issuing instruction stalls combinationally in its own cycle.
- Divide by zero: run the full latency, then hi = Read_data_1 as latched, lo = all ones. No exception.
- div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start while busy: ignored. op and operands are not re-sampled during RUN.
- wr_hi/wr_lo in IDLE: take effect at the next edge; hi and lo are independently writable in the same cycle.
- wr_hi/wr_lo while busy: ignored.
- start and wr_* in the same IDLE cycle: both accepted; the operation result overwrites hi/lo in FIX.
- hi/lo hold their values across RUN and change only at FIX, at reset, or on a wr_* write in IDLE.
- Reset mid-operation: abort immediately, return to reset values, no done pulse.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: mult/multu with Read_data_1==0 or Read_data_2==0 at start goes IDLE -> FIX directly, writing hi=0 and lo=0. done is high in the 3rd cycle after the start cycle; busy is high only during FIX.
- Not defined: every operation takes the full DATA_W+2 latency.
- Division is never short-cut.

Test Plan:
- mult, rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulse exactly 1 cycle, 34 cycles after start; stall_req high from the start cycle through FIX.
- multu, rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, rs=100, rt=7 -> lo=14, hi=2.
- div, rs=0x1234, rt=0 -> hi=0x1234, lo=0xFFFFFFFF.
- mtlo 0xAAAA5555 in IDLE -> lo=0xAAAA5555.
- wr_hi during RUN -> hi unchanged.
- reset asserted at RUN iteration 10 -> next cycle busy=0, hi=lo=0, no done pulse.
- MULDIV_EARLY_OUT_EN defined, mult rs=0, rt=5 -> hi=lo=0, done in the 3rd cycle.
- MULDIV_EARLY_OUT_EN undefined, same stimulus -> done in the 34th cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring shift-subtract step per clock.
// Optional build macro MULDIV_EARLY_OUT_EN short-cuts mult/multu with a zero operand.
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] Read_data_1,
  input  logic [DATA_W-1:0] Read_data_2,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     mag_a_q, mag_a_d;
  logic [DATA_W-1:0]     mag_b_q, mag_b_d;
  logic [DATA_W-1:0]     a_raw_q, a_raw_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div0_q, div0_d;
  logic                  eo_q, eo_d;
  logic                  done_q, done_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;

  logic                  signed_op, a_neg, b_neg, eo_hit;
  logic [DATA_W:0]       mul_sum, div_shift, div_trial;
  logic [2*DATA_W-1:0]   mul_next, div_next, prod_fix;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & Read_data_1[DATA_W-1];
  assign b_neg     = signed_op & Read_data_2[DATA_W-1];

`ifdef MULDIV_EARLY_OUT_EN
  assign eo_hit = ~op[1] & ((Read_data_1 == '0) | (Read_data_2 == '0));
`else
  assign eo_hit = 1'b0;
`endif

  // Multiply: accumulator is {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: accumulator is {remainder, dividend/quotient bits}, shifted left each step.
  assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_trial = div_shift - {1'b0, mag_b_q};
  assign div_next  = div_trial[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                       : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    eo_d      = eo_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          mag_a_d   = a_neg ? -Read_data_1 : Read_data_1;
          mag_b_d   = b_neg ? -Read_data_2 : Read_data_2;
          a_raw_d   = Read_data_1;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (Read_data_2 == '0);
          cnt_d     = '0;
          eo_d      = eo_hit;
          if (eo_hit) begin
            acc_d   = '0;
            state_d = FIX;
          end else begin
            // Multiplier or dividend magnitude seeds the low half.
            acc_d   = {{DATA_W{1'b0}}, (op[1] ? mag_a_d : mag_b_d)};
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIX;
      end
      FIX: begin
        if (eo_q) begin
          // Early-out spends one extra FIX cycle so its completion timing is fixed.
          eo_d = 1'b0;
        end else begin
          if (!is_div_q) begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      eo_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      eo_q      <= eo_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy | (start & (state_q == IDLE));
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: vector table plus hand-written corner sequences.
// Honours MULDIV_EARLY_OUT_EN when choosing the expected latency of zero-operand multiplies.
module tb_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_CYC = 3;
`else
  localparam int EO_CYC = 34;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rd1, rd2, wr_data;
  logic         wr_hi, wr_lo;
  logic         busy, stall_req, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  muldiv_sequencer #(.DATA_W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .Read_data_1 (rd1),
    .Read_data_2 (rd2),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .stall_req   (stall_req),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one operation and return the cycle (1 = cycle after start) in which done is seen.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int dcyc, output bit stall_ok);
    @(negedge clock);
    op = o; rd1 = a; rd2 = b; start = 1'b1;
    #1 stall_ok = stall_req;
    @(negedge clock);
    start = 1'b0;
    rd1 = $urandom; rd2 = $urandom; op = 2'($urandom);
    dcyc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      if (!stall_req) stall_ok = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    int  dcyc;
    bit  stall_ok;
    bit  saw_done;

    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 34};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 34};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       34};
    vecs[4] = '{2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 34};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    vecs[6] = '{2'b00, 32'd0,        32'd5,        32'h00000000, 32'h00000000, EO_CYC};
    vecs[7] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 34};
    vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
    vecs[9] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34};

    reset = 1'b1; start = 1'b0; op = 2'b00; rd1 = '0; rd2 = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall_req), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, dcyc, stall_ok);
      check($sformatf("v%0d_done_cycle", i), 32'(dcyc), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_stall", i), 32'(stall_ok), 32'd1);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      @(negedge clock);
      check($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
    end

    // mtlo alone, then mthi/mtlo together in one IDLE cycle.
    @(negedge clock);
    wr_lo = 1'b1; wr_data = 32'hAAAA5555;
    @(negedge clock);
    wr_lo = 1'b0;
    check("mtlo_lo", lo, 32'hAAAA5555);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0F0F1234;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi_both_hi", hi, 32'h0F0F1234);
    check("mtlo_both_lo", lo, 32'h0F0F1234);

    // start plus mthi in the same IDLE cycle: write lands, then the result overwrites it.
    op = 2'b11; rd1 = 32'd100; rd2 = 32'd7; start = 1'b1; wr_hi = 1'b1; wr_data = 32'h55555555;
    @(negedge clock);
    start = 1'b0; wr_hi = 1'b0;
    check("start_wr_hi_taken", hi, 32'h55555555);
    // mid-run write and restart attempt must both be ignored.
    repeat (4) @(negedge clock);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
    start = 1'b1; op = 2'b00; rd1 = 32'd3; rd2 = 32'd3;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b0; start = 1'b0;
    check("run_wr_hi_ignored", hi, 32'h55555555);
    check("run_wr_lo_ignored", lo, 32'h0F0F1234);
    dcyc = -1;
    for (int c = 6; c <= 60; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clock);
    end
    check("busy_run_done_cycle", 32'(dcyc), 32'd34);
    check("busy_run_hi", hi, 32'd2);
    check("busy_run_lo", lo, 32'd14);

    // Reset at RUN iteration 10 aborts with no done pulse.
    @(negedge clock);
    op = 2'b00; rd1 = 32'd9; rd2 = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clock);
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
